// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
// Holds the FSM state encoding, tick-counter sizing and the 3-sample vote.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic int tcnt_width(input int ovs);
    return $clog2(ovs);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line conditioning: 2-flop synchroniser and a 3-sample majority vote
// taken around mid-bit. bit_value is meaningful on tick OVS/2+1.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVS = 16,
  parameter int TW  = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_tick,
  input  logic          i_rx,
  input  logic [TW-1:0] tcnt,
  output logic          rx_s,
  output logic          bit_value
);

  localparam logic [TW-1:0] T_SMP_A = TW'(OVS/2 - 1);
  localparam logic [TW-1:0] T_SMP_B = TW'(OVS/2);

  logic [1:0] sync_r;
  logic       smp_a_r;
  logic       smp_b_r;

  // Synchroniser and the two early vote samples; the third sample is live rx_s.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_r  <= 2'b11;
      smp_a_r <= 1'b1;
      smp_b_r <= 1'b1;
    end else begin
      sync_r <= {sync_r[0], i_rx};
      if (i_tick && (tcnt == T_SMP_A)) smp_a_r <= sync_r[1];
      if (i_tick && (tcnt == T_SMP_B)) smp_b_r <= sync_r[1];
    end
  end

  assign rx_s      = sync_r[1];
  assign bit_value = maj3(smp_a_r, smp_b_r, rx_s);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: start/data/parity/stop FSM with framing,
// parity and break reporting. Completes at mid last-stop-bit to re-arm early.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int NB_DATA    = 8,
  parameter int OVS        = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int NB_STOP    = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done,
  output logic               o_parity_err,
  output logic               o_frame_err,
  output logic               o_break
);

  localparam int              TW      = tcnt_width(OVS);
  localparam int              BW      = $clog2(NB_DATA);
  localparam logic [TW-1:0]   T_VOTE  = TW'(OVS/2 + 1);
  localparam logic [TW-1:0]   T_LAST  = TW'(OVS - 1);
  localparam logic [BW-1:0]   B_LAST  = BW'(NB_DATA - 1);
  localparam logic            S_LAST  = (NB_STOP == 2);
  localparam logic            PAR_EN  = (PARITY_EN != 0);
  localparam logic            PAR_ODD = (PARITY_ODD != 0);
  localparam state_t          ST_POST = PAR_EN ? ST_PARITY : ST_STOP;

  state_t               state_r, state_s;
  logic [TW-1:0]        tcnt_r, tcnt_s;
  logic [BW-1:0]        bit_cnt_r, bit_cnt_s;
  logic                 stop_cnt_r, stop_cnt_s;
  logic [NB_DATA-1:0]   shreg_r, shreg_s;
  logic                 par_bit_r, par_bit_s;
  logic                 par_err_r, par_err_s;
  logic                 stop_zero_r, stop_zero_s;
  logic                 stop_one_r, stop_one_s;
  logic [NB_DATA-1:0]   data_r, data_s;
  logic                 done_r, done_s;
  logic                 perr_r, perr_s;
  logic                 ferr_r, ferr_s;
  logic                 brk_r, brk_s;
  logic                 rx_s, bit_value_s;
  logic                 tick_vote_s, tick_end_s;

  uart_rx_sampler #(.OVS(OVS), .TW(TW)) u_sampler (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_tick    (i_tick),
    .i_rx      (i_rx),
    .tcnt      (tcnt_r),
    .rx_s      (rx_s),
    .bit_value (bit_value_s)
  );

  assign tick_vote_s = i_tick && (tcnt_r == T_VOTE);
  assign tick_end_s  = i_tick && (tcnt_r == T_LAST);

  // Next-state, frame datapath and completion outputs.
  always_comb begin
    state_s     = state_r;
    bit_cnt_s   = bit_cnt_r;
    stop_cnt_s  = stop_cnt_r;
    shreg_s     = shreg_r;
    par_bit_s   = par_bit_r;
    par_err_s   = par_err_r;
    stop_zero_s = stop_zero_r;
    stop_one_s  = stop_one_r;
    data_s      = data_r;
    perr_s      = perr_r;
    ferr_s      = ferr_r;
    brk_s       = brk_r;
    done_s      = 1'b0;
    if (i_tick) begin
      tcnt_s = (tcnt_r == T_LAST) ? {TW{1'b0}} : tcnt_r + TW'(1'b1);
    end else begin
      tcnt_s = tcnt_r;
    end
    case (state_r)
      ST_IDLE: begin
        tcnt_s      = {TW{1'b0}};
        bit_cnt_s   = {BW{1'b0}};
        stop_cnt_s  = 1'b0;
        par_bit_s   = 1'b0;
        par_err_s   = 1'b0;
        stop_zero_s = 1'b0;
        stop_one_s  = 1'b0;
        if (!rx_s) state_s = ST_START;
        else       state_s = ST_IDLE;
      end
      ST_START: begin
        if (tick_vote_s && bit_value_s) begin
          state_s = ST_IDLE;
          tcnt_s  = {TW{1'b0}};
        end else if (tick_end_s) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_vote_s) shreg_s = {bit_value_s, shreg_r[NB_DATA-1:1]};
        else             shreg_s = shreg_r;
        if (tick_end_s) begin
          if (bit_cnt_r == B_LAST) begin
            bit_cnt_s = {BW{1'b0}};
            state_s   = ST_POST;
          end else begin
            bit_cnt_s = bit_cnt_r + BW'(1'b1);
          end
        end else begin
          bit_cnt_s = bit_cnt_r;
        end
      end
      ST_PARITY: begin
        if (tick_vote_s) begin
          par_bit_s = bit_value_s;
          par_err_s = (^shreg_r) ^ bit_value_s ^ PAR_ODD;
        end else begin
          par_bit_s = par_bit_r;
        end
        if (tick_end_s) state_s = ST_STOP;
        else            state_s = ST_PARITY;
      end
      ST_STOP: begin
        if (tick_vote_s) begin
          stop_zero_s = stop_zero_r | ~bit_value_s;
          stop_one_s  = stop_one_r | bit_value_s;
          // Last stop bit: publish the frame now rather than at bit end.
          if (stop_cnt_r == S_LAST) begin
            data_s  = shreg_r;
            perr_s  = PAR_EN & par_err_r;
            ferr_s  = stop_zero_r | ~bit_value_s;
            brk_s   = (shreg_r == {NB_DATA{1'b0}}) & ~stop_one_r & ~bit_value_s
                      & ~(PAR_EN & par_bit_r);
            done_s  = 1'b1;
            state_s = ST_IDLE;
            tcnt_s  = {TW{1'b0}};
          end else begin
            state_s = ST_STOP;
          end
        end else if (tick_end_s) begin
          stop_cnt_s = 1'b1;
        end else begin
          stop_cnt_s = stop_cnt_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        tcnt_s  = {TW{1'b0}};
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r     <= ST_IDLE;
      tcnt_r      <= {TW{1'b0}};
      bit_cnt_r   <= {BW{1'b0}};
      stop_cnt_r  <= 1'b0;
      shreg_r     <= {NB_DATA{1'b0}};
      par_bit_r   <= 1'b0;
      par_err_r   <= 1'b0;
      stop_zero_r <= 1'b0;
      stop_one_r  <= 1'b0;
      data_r      <= {NB_DATA{1'b0}};
      done_r      <= 1'b0;
      perr_r      <= 1'b0;
      ferr_r      <= 1'b0;
      brk_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      tcnt_r      <= tcnt_s;
      bit_cnt_r   <= bit_cnt_s;
      stop_cnt_r  <= stop_cnt_s;
      shreg_r     <= shreg_s;
      par_bit_r   <= par_bit_s;
      par_err_r   <= par_err_s;
      stop_zero_r <= stop_zero_s;
      stop_one_r  <= stop_one_s;
      data_r      <= data_s;
      done_r      <= done_s;
      perr_r      <= perr_s;
      ferr_r      <= ferr_s;
      brk_r       <= brk_s;
    end
  end

  assign o_rx_data    = data_r;
  assign o_rx_done    = done_r;
  assign o_parity_err = perr_r;
  assign o_frame_err  = ferr_r;
  assign o_break      = brk_r;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 8E1, 8N2) on separate lines,
// a frame-level expectation model and a per-cycle output compare.
module tb_uart_rx_cfg;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
  } exp_t;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_tick;
  logic [2:0] rx_line;
  logic [7:0] rx_data_w [3];
  logic [2:0] done_w, perr_w, ferr_w, brk_w;

  int   pe_cfg [3] = '{0, 1, 0};
  int   ns_cfg [3] = '{1, 1, 2};
  int   tick_div = 1;
  int   tick_cnt = 0;
  int   n_checks = 0;
  int   n_err = 0;

  exp_t exp_buf [3][16];
  int   wr_p [3] = '{0, 0, 0};
  int   rd_p [3] = '{0, 0, 0};
  exp_t held [3];

  always #5 i_clk = ~i_clk;

  uart_rx_cfg #(.NB_DATA(8), .OVS(16), .PARITY_EN(0), .PARITY_ODD(0), .NB_STOP(1)) dut_8n1 (
    .i_clk(i_clk), .i_reset(i_reset), .i_tick(i_tick), .i_rx(rx_line[0]),
    .o_rx_data(rx_data_w[0]), .o_rx_done(done_w[0]), .o_parity_err(perr_w[0]),
    .o_frame_err(ferr_w[0]), .o_break(brk_w[0]));

  uart_rx_cfg #(.NB_DATA(8), .OVS(16), .PARITY_EN(1), .PARITY_ODD(0), .NB_STOP(1)) dut_8e1 (
    .i_clk(i_clk), .i_reset(i_reset), .i_tick(i_tick), .i_rx(rx_line[1]),
    .o_rx_data(rx_data_w[1]), .o_rx_done(done_w[1]), .o_parity_err(perr_w[1]),
    .o_frame_err(ferr_w[1]), .o_break(brk_w[1]));

  uart_rx_cfg #(.NB_DATA(8), .OVS(16), .PARITY_EN(0), .PARITY_ODD(0), .NB_STOP(2)) dut_8n2 (
    .i_clk(i_clk), .i_reset(i_reset), .i_tick(i_tick), .i_rx(rx_line[2]),
    .o_rx_data(rx_data_w[2]), .o_rx_done(done_w[2]), .o_parity_err(perr_w[2]),
    .o_frame_err(ferr_w[2]), .o_break(brk_w[2]));

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Frame-level rules: what a receiver must report for the given line bits.
  function automatic exp_t model(input int inst, input logic [7:0] d, input logic p,
                                 input logic [1:0] stops);
    exp_t e;
    logic any_zero, all_zero;
    any_zero = (stops[0] == 1'b0) || (ns_cfg[inst] == 2 && stops[1] == 1'b0);
    all_zero = (stops[0] == 1'b0) && (ns_cfg[inst] == 1 || stops[1] == 1'b0);
    e.data = d;
    e.pe   = (pe_cfg[inst] != 0) && ((^d) != p);
    e.fe   = any_zero;
    e.brk  = (d == 8'h00) && all_zero && (pe_cfg[inst] == 0 || p == 1'b0);
    return e;
  endfunction

  task automatic send(input int inst, input logic [7:0] d, input logic p, input logic [1:0] stops,
                      input int bit_x100, input int glitch_bit, input int abort_bit);
    logic bits [12];
    int   n, acc, t0, len;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    n = 9;
    if (pe_cfg[inst] != 0) begin bits[n] = p; n++; end
    for (int s = 0; s < ns_cfg[inst]; s++) begin bits[n] = stops[s]; n++; end
    if (abort_bit < 0) begin
      exp_buf[inst][wr_p[inst] % 16] = model(inst, d, p, stops);
      wr_p[inst]++;
    end
    acc = 0;
    for (int b = 0; b < n; b++) begin
      t0 = acc / 100;
      acc += bit_x100;
      len = acc / 100 - t0;
      for (int c = 0; c < len; c++) begin
        if (b == abort_bit && c == 8) begin
          rx_line[inst] = 1'b1;
          i_reset = 1'b1;
          step();
          step();
          i_reset = 1'b0;
          step();
          return;
        end
        rx_line[inst] = (b == glitch_bit && c == 9) ? ~bits[b] : bits[b];
        step();
      end
    end
    rx_line[inst] = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain(input int inst);
    int k;
    k = 0;
    while (rd_p[inst] != wr_p[inst] && k < 600) begin step(); k++; end
    chk($sformatf("drain%0d_pending", inst), wr_p[inst] - rd_p[inst], 0);
    idle(20);
  endtask

  // Oversample tick: one pulse every tick_div clocks.
  initial begin
    i_tick = 1'b0;
    forever begin
      step();
      tick_cnt = (tick_cnt + 1) % tick_div;
      i_tick = (tick_cnt == 0);
    end
  end

  // Compare every cycle: done pops the model, otherwise outputs must hold.
  initial begin
    exp_t act;
    for (int i = 0; i < 3; i++) held[i] = '0;
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        for (int i = 0; i < 3; i++) begin
          rd_p[i] = wr_p[i];
          held[i] = '0;
        end
      end else begin
        for (int i = 0; i < 3; i++) begin
          act = {rx_data_w[i], perr_w[i], ferr_w[i], brk_w[i]};
          if (done_w[i]) begin
            if (rd_p[i] == wr_p[i]) begin
              chk($sformatf("spurious_done%0d", i), 32'd1, 32'd0);
            end else begin
              held[i] = exp_buf[i][rd_p[i] % 16];
              rd_p[i]++;
              chk($sformatf("frame%0d", i), 32'(act), 32'(held[i]));
            end
          end else begin
            chk($sformatf("hold%0d", i), 32'(act), 32'(held[i]));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin
    i_reset = 1'b1;
    rx_line = 3'b111;
    idle(3);
    i_reset = 1'b0;
    step();
    chk("reset_data", rx_data_w[0], 8'h00);
    chk("reset_flags", {done_w, perr_w, ferr_w, brk_w}, 12'h000);

    // 8N1 0xA5, tick every other clock
    tick_div = 2;
    idle(20);
    send(0, 8'hA5, 1'b0, 2'b11, 3200, -1, -1);
    drain(0);
    chk("t1_data", rx_data_w[0], 8'hA5);
    chk("t1_flags", {perr_w[0], ferr_w[0], brk_w[0]}, 3'b000);
    tick_div = 1;
    idle(20);

    // 8E1 parity good then bad
    send(1, 8'h03, 1'b0, 2'b11, 1600, -1, -1);
    drain(1);
    chk("t2_perr_ok", perr_w[1], 1'b0);
    send(1, 8'h03, 1'b1, 2'b11, 1600, -1, -1);
    drain(1);
    chk("t2_perr_bad", {rx_data_w[1], perr_w[1]}, {8'h03, 1'b1});

    // Framing error, then a full break frame
    send(0, 8'h5A, 1'b0, 2'b00, 1600, -1, -1);
    drain(0);
    chk("t3_ferr", {rx_data_w[0], ferr_w[0], brk_w[0]}, {8'h5A, 1'b1, 1'b0});
    send(0, 8'h00, 1'b0, 2'b00, 1600, -1, -1);
    drain(0);
    chk("t3_break", {rx_data_w[0], ferr_w[0], brk_w[0]}, {8'h00, 1'b1, 1'b1});

    // False start: 4-tick low glitch must leave previous frame's outputs alone
    rx_line[0] = 1'b0;
    idle(4);
    rx_line[0] = 1'b1;
    idle(60);
    chk("t4_false_start", {rx_data_w[0], brk_w[0]}, {8'h00, 1'b1});
    // Single-tick glitch on data bit 3 (line bit index 4)
    send(0, 8'hA5, 1'b0, 2'b11, 1600, 4, -1);
    drain(0);
    chk("t4_glitch_lo", rx_data_w[0], 8'hA5);
    send(0, 8'h08, 1'b0, 2'b11, 1600, 4, -1);
    drain(0);
    chk("t4_glitch_hi", rx_data_w[0], 8'h08);

    // 8N2 back-to-back, transmitter 2% slow
    send(2, 8'h11, 1'b0, 2'b11, 1632, -1, -1);
    send(2, 8'h22, 1'b0, 2'b11, 1632, -1, -1);
    send(2, 8'h33, 1'b0, 2'b11, 1632, -1, -1);
    drain(2);
    chk("t5_last", rx_data_w[2], 8'h33);
    chk("t5_count", rd_p[2], 3);

    // Reset during data bit 4, then a clean frame
    send(0, 8'hFF, 1'b0, 2'b11, 1600, -1, 5);
    idle(40);
    chk("t6_reset_out", {rx_data_w[0], perr_w[0], ferr_w[0], brk_w[0]}, 11'h000);
    chk("t6_other_out", {rx_data_w[1], rx_data_w[2]}, 16'h0000);
    send(0, 8'hC3, 1'b0, 2'b11, 1600, -1, -1);
    drain(0);
    chk("t6_after", {rx_data_w[0], ferr_w[0]}, {8'hC3, 1'b0});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
